// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) running on the system clock.
// The external sck/ss/mosi pins are oversampled through two-flop synchronizers.
// Edges are detected on the synchronized copies. Each received frame is
// presented on data_out with a one-cycle new_data strobe. The reply word
// captured from data_in is shifted out on miso.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains plus one history stage for edge detection
  logic ss_meta_q, ss_s_q, ss_hist_q;
  logic sck_meta_q, sck_s_q, sck_hist_q;
  logic mosi_meta_q, mosi_s_q;

  // Frame state and registered outputs
  state_t                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [DATA_WIDTH-2:0]   rx_shift_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    new_data_q;
  logic                    busy_q;

  logic ss_fall, ss_rise, sck_rise, sck_fall;
  logic [DATA_WIDTH-1:0] rx_next;

  assign ss_fall  =  ss_hist_q  & ~ss_s_q;
  assign ss_rise  = ~ss_hist_q  &  ss_s_q;
  assign sck_rise = ~sck_hist_q &  sck_s_q;
  assign sck_fall =  sck_hist_q & ~sck_s_q;

  // The newest bit joins the stored bits here. The top bit of a frame is only
  // ever needed for data_out, so rx_shift_q holds one bit less than a frame.
  assign rx_next = {rx_shift_q, mosi_s_q};

  // Pin synchronizers and edge-detect history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the ss chain resets to 0 (selected), not 1. A master already
      // holding ss low at reset release then produces no ss_fall. That frame
      // is ignored until ss rises and falls again.
      ss_meta_q   <= 1'b0;
      ss_s_q      <= 1'b0;
      ss_hist_q   <= 1'b0;
      sck_meta_q  <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_hist_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // value of its neighbour, so the chain really is N flops deep.
      ss_meta_q   <= ss;
      ss_s_q      <= ss_meta_q;
      ss_hist_q   <= ss_s_q;
      sck_meta_q  <= sck;
      sck_s_q     <= sck_meta_q;
      sck_hist_q  <= sck_s_q;
      mosi_meta_q <= mosi;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  // Frame FSM: select/deselect, bit capture, reply shifting, output strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      data_out_q <= '0;
      new_data_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // sck activity while deselected is ignored. A coincident sck_rise
          // at select only sees the reply load.
          if (ss_fall) begin
            state_q    <= ACTIVE;
            tx_shift_q <= data_in;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            // Deselect wins over any coincident sck edge. The partial frame
            // is dropped.
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else if (sck_rise) begin
            rx_shift_q <= rx_next[DATA_WIDTH-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              data_out_q <= rx_next;
              new_data_q <= 1'b1;
              bit_cnt_q  <= '0;
              tx_shift_q <= data_in;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sck_fall) begin
            // At a frame boundary the freshly loaded MSB must stay on miso
            // for the first bit of the next frame.
            if (bit_cnt_q != '0) begin
              tx_shift_q <= tx_shift_q << 1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso     = busy_q & tx_shift_q[DATA_WIDTH-1];
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign busy     = busy_q;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) and the peripheral-side counterpart of the codebase's `spi_master`. It runs entirely on the system clock, oversampling the external `sck`, `ss` and `mosi` pins through synchronizers. It delivers each received byte with a one-cycle `new_data` strobe and shifts a reply byte out on `miso`. It sits between the SPI pins and the SoC peripheral bus, so the J1 core can act as an SPI target.

## Interface
- `DATA_WIDTH`, default 8: frame length in bits. The bit counter is $clog2(DATA_WIDTH) wide.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `ss`, input, 1: slave select from the pin, active-low, asynchronous to `clk`.
- `sck`, input, 1: SPI clock from the pin, asynchronous to `clk`.
- `mosi`, input, 1: serial data from the master.
- `miso`, output, 1: serial data to the master. Forced to 0 while deselected.
- `data_in`, input, DATA_WIDTH: reply byte. Captured at frame start and at each byte boundary.
- `data_out`, output, DATA_WIDTH: last complete received byte. Holds until the next byte completes.
- `new_data`, output, 1: one-cycle pulse when `data_out` is updated.
- `busy`, output, 1: high while selected (synchronized `ss` low).

## Operation
- Synchronizers: two flops each on `ss`, `sck` and `mosi`, giving `ss_s`, `sck_s` and `mosi_s`.
  - One more history flop on each of `ss_s` and `sck_s` feeds the edge detect.
  - Detected events: `ss_fall`, `ss_rise`, `sck_rise`, `sck_fall`.
- States:
  - IDLE (`ss_s`=1).
  - ACTIVE (`ss_s`=0).
- IDLE -> ACTIVE on `ss_fall`:
  - `tx_shift <= data_in`
  - `bit_cnt <= 0`
  - `busy <= 1`
- In ACTIVE, on `sck_rise`:
  - `rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s}`
  - `bit_cnt` increments.
- In ACTIVE, on `sck_rise` with `bit_cnt == DATA_WIDTH-1`, the byte is complete:
  - `data_out <= {rx_shift[DATA_WIDTH-2:0], mosi_s}`
  - `new_data <= 1` for exactly one cycle.
  - `bit_cnt` wraps to 0.
  - `tx_shift <= data_in`, which reloads the reply for back-to-back bytes.
- In ACTIVE, on `sck_fall`:
  - If `bit_cnt != 0`: `tx_shift <= tx_shift << 1`.
  - If `bit_cnt == 0`: no shift. This keeps the reloaded MSB in place.
- `miso` = `tx_shift[DATA_WIDTH-1]` when `busy`=1, else 0. It is registered-source and never driven from `ss`/`sck` combinationally.
- ACTIVE -> IDLE on `ss_rise`, at any bit position:
  - `busy <= 0`, `bit_cnt <= 0`.
  - The partial byte is discarded: no `new_data`, `data_out` unchanged.
- Edges on `sck` while in IDLE are ignored: no counting, no shifting.
- Simultaneous events in the same cycle:
  - `ss_rise` and `sck_rise`: `ss_rise` wins. No bit is captured and no `new_data` is raised.
  - `ss_fall` and `sck_rise`: only the load happens. Mode 0 requires the master to keep `sck` low at select.
- Reset (`rst`=0, at any time, including mid-frame):
  - `miso`=0, `data_out`=0, `new_data`=0, `busy`=0.
  - Shift registers and `bit_cnt` cleared.
  - State = IDLE.
  - After release, the block waits for a fresh `ss_fall`. A frame already in progress, with `ss` low at release, is ignored until `ss` rises and falls again.

## Timing
- Pin-to-action latency is 3 `clk` edges: the sampling edge, the second sync stage, then the registered action.
  - `new_data` rises on the 3rd `clk` edge after the edge that first samples the final `sck` high.
  - `busy` rises 3 edges after `ss` is first sampled low.
- `sck` high and low phases must each be at least 4 `clk` periods. `ss` setup to first `sck` rise and hold after last `sck` fall must also be at least 4 `clk` periods.
- `miso` changes at most 3 `clk` after `sck` falls, or after the `sck` rise on a byte boundary. It is stable at the master's next rising edge.
- `data_in` must be stable from `ss` falling + 3 `clk`, and around each byte-boundary `sck_rise`. It may change in the cycle after `new_data`.
- `new_data` is never high for two consecutive cycles.

## Test plan
- Reset: hold `rst`=0 with random pin activity -> `miso`=0, `data_out`=0x00, `new_data`=0, `busy`=0 throughout.
- Single byte, sck period 8 `clk`: `data_in`=0xA5, master sends 0x5C -> `data_out`=0x5C with a single `new_data` pulse; master samples `miso` 1,0,1,0,0,1,0,1 (0xA5).
- Back-to-back bytes with `ss` held low: master sends 0x3C then 0xC3; `data_in`=0x81, changed to 0x0F in the cycle after the first `new_data` -> two `new_data` pulses with `data_out` 0x3C then 0xC3; master receives 0x81 then 0x0F.
- Abort: `ss` raised after 5 bits of 0xFF -> no `new_data`, `data_out` unchanged, `busy` falls 3 `clk` later; the next frame 0x42 is received correctly.
- Reset mid-frame after 3 bits -> all outputs return to reset values; after `ss` rises and falls again, 0x99 is received correctly.
- Deselected: `ss`=1 with 16 `sck` pulses and `mosi` toggling -> no `new_data`, `busy`=0, `miso`=0.
